// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller for the F/D/E/M/W pipeline: load-use, redirect, MDU wait with timeout, memory waits, pending traps.
// Optional perf counters are compiled in when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int OPINFO_W    = 12,
  parameter int LOAD_BIT    = 3,
  parameter int REG_W       = 5,
  parameter int MDU_MAX_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                execute_i_need_jump,
  input  logic [OPINFO_W-1:0] regE_i_opcode_info,
  input  logic [REG_W-1:0]    regE_i_rd,
  input  logic [REG_W-1:0]    decode_i_rs1,
  input  logic [REG_W-1:0]    decode_i_rs2,
  input  logic                decode_i_use_rs1,
  input  logic                decode_i_use_rs2,
  input  logic                ifetch_i_busy,
  input  logic                mem_i_busy,
  input  logic                mdu_i_start,
  input  logic                mdu_i_done,
  input  logic                trap_i_valid,
  output logic                regF_stall,
  output logic                regD_stall,
  output logic                regE_stall,
  output logic                regM_stall,
  output logic                regW_stall,
  output logic                regF_bubble,
  output logic                regD_bubble,
  output logic                regE_bubble,
  output logic                regM_bubble,
  output logic                regW_bubble,
  output logic [1:0]          ctrl_o_state,
  output logic                ctrl_o_trap_take,
  output logic                ctrl_o_mdu_timeout,
  output logic [CNT_W-1:0]    perf_o_stall_cnt,
  output logic [CNT_W-1:0]    perf_o_flush_cnt,
  output logic [CNT_W-1:0]    perf_o_lduse_cnt
);

  localparam int TMO_W = $clog2(MDU_MAX_CYC);

  typedef enum logic {MDU_IDLE = 1'b0, MDU_BUSY = 1'b1} mduState_t;

  mduState_t        mduStateReg, mduStateNext;
  logic             trapPendReg, trapPendNext;
  logic [TMO_W-1:0] tmoCntReg, tmoCntNext;

  logic mduBusy, rs1Hit, rs2Hit, loadUse, trapReq, trapTake, mduTimeout, mduHold;
  logic unusedOpInfo;

  assign unusedOpInfo = ^regE_i_opcode_info;

  assign mduBusy  = (mduStateReg == MDU_BUSY);
  assign rs1Hit   = decode_i_use_rs1 && (decode_i_rs1 == regE_i_rd);
  assign rs2Hit   = decode_i_use_rs2 && (decode_i_rs2 == regE_i_rd);
  assign loadUse  = regE_i_opcode_info[LOAD_BIT] && (rs1Hit || rs2Hit) && (regE_i_rd != '0);
  assign trapReq  = trap_i_valid || trapPendReg;
  assign trapTake = trapReq && !mem_i_busy;

  // A timeout releases the hold in the same cycle so the E instruction advances.
  assign mduTimeout = mduBusy && !mdu_i_done && !trapTake &&
                      (tmoCntReg == TMO_W'(MDU_MAX_CYC - 1));
  assign mduHold    = mduBusy ? (!mdu_i_done && !mduTimeout)
                              : (mdu_i_start && !mdu_i_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mduStateReg <= MDU_IDLE;
      trapPendReg <= 1'b0;
      tmoCntReg   <= '0;
    end else begin
      mduStateReg <= mduStateNext;
      trapPendReg <= trapPendNext;
      tmoCntReg   <= tmoCntNext;
    end
  end

  always_comb begin
    mduStateNext = mduStateReg;
    trapPendNext = trapPendReg;
    tmoCntNext   = tmoCntReg;
    if (trapTake) begin
      trapPendNext = 1'b0;
      mduStateNext = MDU_IDLE;
      tmoCntNext   = '0;
    end else begin
      if (mem_i_busy && trap_i_valid) begin
        trapPendNext = 1'b1;
      end
      if (mduStateReg == MDU_IDLE) begin
        if (mdu_i_start && !mdu_i_done) begin
          mduStateNext = MDU_BUSY;
          tmoCntNext   = '0;
        end
      end else if (mdu_i_done || mduTimeout) begin
        mduStateNext = MDU_IDLE;
        tmoCntNext   = '0;
      end else begin
        tmoCntNext = tmoCntReg + TMO_W'(1);
      end
    end
  end

  always_comb begin
    regF_stall  = 1'b0;
    regD_stall  = 1'b0;
    regE_stall  = 1'b0;
    regM_stall  = 1'b0;
    regF_bubble = 1'b0;
    regD_bubble = 1'b0;
    regE_bubble = 1'b0;
    regM_bubble = 1'b0;
    regW_bubble = 1'b0;
    if (trapTake) begin
      regD_bubble = 1'b1;
      regE_bubble = 1'b1;
      regM_bubble = 1'b1;
    end else if (mem_i_busy) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_stall  = 1'b1;
      regM_stall  = 1'b1;
      regW_bubble = 1'b1;
    end else if (mduHold) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_stall  = 1'b1;
      regM_bubble = 1'b1;
    end else if (execute_i_need_jump) begin
      regD_bubble = 1'b1;
      regE_bubble = 1'b1;
      regF_stall  = ifetch_i_busy;
    end else if (loadUse) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_bubble = 1'b1;
    end else if (ifetch_i_busy) begin
      regF_stall  = 1'b1;
      regD_bubble = 1'b1;
    end
  end

  assign regW_stall         = 1'b0;
  assign ctrl_o_state       = {trapPendReg, mduBusy};
  assign ctrl_o_trap_take   = trapTake;
  assign ctrl_o_mdu_timeout = mduTimeout;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic                       flushEvt, ldUseEvt;
  logic [2:0]                 perfEvt;
  logic [2:0][CNT_W-1:0]      perfCnt;

  assign flushEvt = trapTake || (!mem_i_busy && !mduHold && execute_i_need_jump);
  assign ldUseEvt = !trapTake && !mem_i_busy && !mduHold && !execute_i_need_jump && loadUse;
  assign perfEvt  = {ldUseEvt, flushEvt, regF_stall};

  // Index 0: stall cycles, 1: flushes, 2: load-use cycles; all wrap naturally.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : genPerf
      logic [CNT_W-1:0] cntReg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cntReg <= '0;
        end else if (perfEvt[gi]) begin
          cntReg <= cntReg + CNT_W'(1);
        end
      end
      assign perfCnt[gi] = cntReg;
    end
  endgenerate

  assign perf_o_stall_cnt = perfCnt[0];
  assign perf_o_flush_cnt = perfCnt[1];
  assign perf_o_lduse_cnt = perfCnt[2];
`else
  assign perf_o_stall_cnt = '0;
  assign perf_o_flush_cnt = '0;
  assign perf_o_lduse_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard/stall controller for the 5-stage F/D/E/M/W core. It generates per-stage stall and bubble controls.
- Beyond load-use and branch flush, it handles:
  - multi-cycle MDU ops, tracked by an FSM with a timeout;
  - instruction- and data-memory wait states;
  - traps arriving while memory is busy, held as a pending trap.
- Sits beside the pipeline registers and drives their stall/bubble inputs directly.

Parameters:
OPINFO_W, 12, width of regE_i_opcode_info
LOAD_BIT, 3, bit index of "is load" in opcode info
REG_W, 5, register index width
MDU_MAX_CYC, 64, max MDU busy cycles before timeout (>=2)
CNT_W, 32, perf counter width

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
execute_i_need_jump  in  1  E-stage redirect (branch/jump taken)
regE_i_opcode_info  in  OPINFO_W  E-stage opcode class bits
regE_i_rd  in  REG_W  E-stage destination register
decode_i_rs1  in  REG_W  D-stage source 1
decode_i_rs2  in  REG_W  D-stage source 2
decode_i_use_rs1  in  1  D instruction reads rs1
decode_i_use_rs2  in  1  D instruction reads rs2
ifetch_i_busy  in  1  instruction memory not ready
mem_i_busy  in  1  data memory not ready (M-stage access in flight)
mdu_i_start  in  1  E-stage multi-cycle MDU op issuing
mdu_i_done  in  1  MDU result valid this cycle
trap_i_valid  in  1  W-stage trap/exception request (1-cycle pulse)
regF_stall/regD_stall/regE_stall/regM_stall/regW_stall  out  1 each  hold stage register
regF_bubble/regD_bubble/regE_bubble/regM_bubble/regW_bubble  out  1 each  insert NOP into stage register
ctrl_o_state  out  2  00 RUN, 01 MDU_BUSY, 10 TRAP_PEND, 11 TRAP_PEND+MDU_BUSY
ctrl_o_trap_take  out  1  trap applied this cycle (redirect strobe for PC logic)
ctrl_o_mdu_timeout  out  1  1-cycle pulse on MDU timeout
perf_o_stall_cnt  out  CNT_W  cycles with regF_stall=1
perf_o_flush_cnt  out  CNT_W  jump flushes + traps taken
perf_o_lduse_cnt  out  CNT_W  load-use stall cycles

Behaviour:
- Reset (async, rst_n=0):
  - mdu_busy=0, trap_pend=0, timeout counter=0, perf counters=0.
  - Stall/bubble outputs are combinational; all are 0 when inputs are idle.
- Derived signals:
  - load_use = regE_i_opcode_info[LOAD_BIT] & ((use_rs1 & rs1==rd) | (use_rs2 & rs2==rd)) & (regE_i_rd!=0).
  - mdu_hold = (!mdu_busy & mdu_i_start & !mdu_i_done) | (mdu_busy & !mdu_i_done).
  - trap_req = trap_i_valid | trap_pend.
- Priority, first match wins (unlisted outputs are 0):
  1. trap_req & !mem_i_busy:
     - regD/E/M_bubble=1, ctrl_o_trap_take=1.
     - trap_pend clears; mdu_busy clears and the timeout counter clears (MDU aborted).
  2. mem_i_busy:
     - F/D/E/M stall=1, regW_bubble=1.
     - If trap_i_valid, set trap_pend. MDU FSM still tracks mdu_i_done.
  3. mdu_hold: F/D/E stall=1, regM_bubble=1.
  4. execute_i_need_jump: regD_bubble=1, regE_bubble=1.
  5. load_use: regF_stall=1, regD_stall=1, regE_bubble=1.
  6. ifetch_i_busy: regF_stall=1, regD_bubble=1.
- In cases 4 and 5, ifetch_i_busy additionally forces regF_stall=1.
- MDU FSM:
  - IDLE -> BUSY on mdu_i_start & !mdu_i_done & !(case 1).
  - BUSY -> IDLE on mdu_i_done, on trap taken, or on timeout.
  - Start and done in the same cycle: stays IDLE, no stall.
- Timeout:
  - Counter increments each BUSY cycle without done.
  - When it reaches MDU_MAX_CYC-1 without done: ctrl_o_mdu_timeout pulses, FSM -> IDLE, counter -> 0. The E instruction then advances.
- trap_pend:
  - Sticky until taken.
  - A second trap_i_valid while pending is absorbed (single trap taken).
- Write side is never stalled: regW_stall is constant 0.

Optional Feature:
- Macro PIPE_HAZARD_CTRL_PERF_EN.
- Defined: perf counters are live.
  - stall_cnt +1 per regF_stall cycle.
  - flush_cnt +1 per cycle where case 4 or case 1 applies.
  - lduse_cnt +1 per case-5 cycle.
  - Counters wrap modulo 2^CNT_W.
- Undefined: counter registers absent; perf_o_* tied to 0.

Test Plan:
- Reset: rst_n=0 mid-MDU_BUSY with trap_pend=1 -> ctrl_o_state=00 immediately, all stall/bubble 0 with idle inputs.
- Load-use: E load rd=5, D rs1=5 use_rs1=1 -> F/D stall=1, E bubble=1.
  - Same with rd=0, or use_rs1=0 -> no stall.
  - Jump in the same cycle -> D/E bubble only.
- MDU: mdu_i_start at cycle 0, done at cycle 4 -> F/D/E stall and M bubble for cycles 0..3, state=01 for cycles 1..4, cycle 5 clean.
  - Start+done same cycle -> no stall.
- MDU timeout (MDU_MAX_CYC=8): start, never done -> ctrl_o_mdu_timeout pulses on the 8th busy cycle, state returns to 00 next cycle.
- Trap during mem wait: mem_i_busy=1 for 3 cycles, trap_i_valid at cycle 1 -> state=10 for cycles 2..3; cycle 3 trap_take=1 with D/E/M bubble once busy drops, pend cleared.
- Perf (macro on): 3 load-use cycles + 2 jumps -> lduse_cnt=3, flush_cnt=2, stall_cnt=3. Macro off -> all counters 0.
